// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane integrator.
// Accumulates signed synaptic currents into a saturating membrane potential.
// At each timestep boundary it applies a shift-based leak, presents the
// post-leak potential for one cycle, and then fires by subtracting the
// threshold when the potential has reached it.
module lif_membrane_integrator #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_TIMESTEPS = 8,
  parameter int TS_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         current_valid,
  output logic                         current_ready,
  input  logic signed [DATA_WIDTH-1:0] current,
  input  logic                         timestep_end,
  input  logic [3:0]                   leak_shift,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic signed [DATA_WIDTH-1:0] membrane_potential,
  output logic                         potential_valid,
  output logic [TS_WIDTH-1:0]          timestep_count,
  output logic                         busy,
  output logic                         done
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    LEAK      = 2'd2,
    EMIT      = 2'd3
  } state_t;

  state_t                state, state_next;
  logic signed [W-1:0]   v, v_next;
  logic [TS_WIDTH-1:0]   ts, ts_next;
  logic                  done_next;
  logic                  last_ts;
  logic [W:0]            sum_ext;
  logic [W:0]            diff_ext;

  // Clamp a W+1 bit result into the W-bit signed range. Overflow shows up
  // as the two top bits disagreeing; the top bit then gives the direction.
  function automatic logic signed [W-1:0] sat(input logic [W:0] x);
    if (x[W] != x[W-1]) begin
      return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return x[W-1:0];
  endfunction

  // Sign-extended one bit so add/subtract cannot wrap before clamping.
  assign sum_ext  = {v[W-1], v} + {current[W-1], current};
  assign diff_ext = {v[W-1], v} - {threshold[W-1], threshold};
  assign last_ts  = (ts == TS_WIDTH'(NUM_TIMESTEPS - 1));

  // Next-state, next-potential and next-timestep decode.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    v_next     = v;
    ts_next    = ts;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          v_next     = '0;
          ts_next    = '0;
          state_next = INTEGRATE;
        end
      end
      INTEGRATE: begin
        // A current arriving with timestep_end still belongs to this timestep.
        if (current_valid) v_next = sat(sum_ext);
        if (timestep_end) state_next = LEAK;
      end
      LEAK: begin
        // v - (v >>> s) moves v toward zero and can never overflow.
        if (leak_shift != 4'd0) v_next = v - (v >>> leak_shift);
        state_next = EMIT;
      end
      EMIT: begin
        if (v >= threshold) v_next = sat(diff_ext);
        if (last_ts) begin
          done_next  = 1'b1;
          ts_next    = '0;
          state_next = IDLE;
        end else begin
          ts_next    = ts + TS_WIDTH'(1);
          state_next = INTEGRATE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, potential, timestep counter and done pulse registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      v     <= '0;
      ts    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      v     <= v_next;
      ts    <= ts_next;
      done  <= done_next;
    end
  end

  assign membrane_potential = v;
  assign timestep_count     = ts;
  assign potential_valid    = (state == EMIT);
  assign busy               = (state != IDLE);
  assign current_ready      = (state == INTEGRATE);

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed self-checking bench for lif_membrane_integrator.
// Inputs change 1 ns after the rising edge; outputs are checked at the same
// point, i.e. showing the state registered by the preceding edge.
module tb_lif_membrane_integrator;

  logic               clk;
  logic               rstn;
  logic               start;
  logic               current_valid;
  logic               current_ready;
  logic signed [15:0] current;
  logic               timestep_end;
  logic [3:0]         leak_shift;
  logic signed [15:0] threshold;
  logic signed [15:0] mp;
  logic               potential_valid;
  logic [7:0]         timestep_count;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  lif_membrane_integrator #(
    .DATA_WIDTH(16),
    .NUM_TIMESTEPS(4),
    .TS_WIDTH(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .current_valid(current_valid),
    .current_ready(current_ready),
    .current(current),
    .timestep_end(timestep_end),
    .leak_shift(leak_shift),
    .threshold(threshold),
    .membrane_potential(mp),
    .potential_valid(potential_valid),
    .timestep_count(timestep_count),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count potential_valid pulses independently of the directed steps.
  always @(posedge clk) begin
    if (rstn && potential_valid) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with random inputs.
    rstn          = 1'b0;
    start         = 1'($urandom);
    current_valid = 1'($urandom);
    current       = 16'($urandom);
    timestep_end  = 1'($urandom);
    leak_shift    = 4'($urandom);
    threshold     = 16'($urandom);
    tick();
    start         = 1'($urandom);
    current_valid = 1'($urandom);
    current       = 16'($urandom);
    timestep_end  = 1'($urandom);
    tick();
    start = 1'b0; current_valid = 1'b0; current = '0; timestep_end = 1'b0;
    check("rst_mp",    32'(mp), 0);
    check("rst_pv",    32'(potential_valid), 0);
    check("rst_done",  32'(done), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ready", 32'(current_ready), 0);
    check("rst_ts",    32'(timestep_count), 0);
    rstn = 1'b1;
    tick();

    // Spike and subtract: 100 + 60 = 160, leak 160-40 = 120, fire -> 20.
    leak_shift = 4'd2;
    threshold  = 16'sd100;
    do_start();
    check("t2_busy",  32'(busy), 1);
    check("t2_ready", 32'(current_ready), 1);
    check("t2_ts0",   32'(timestep_count), 0);
    check("t2_v0",    32'(mp), 0);
    current_valid = 1'b1; current = 16'sd100;
    tick();
    check("t2_acc100", 32'(mp), 100);
    current = 16'sd60;
    tick();
    check("t2_acc160", 32'(mp), 160);
    current_valid = 1'b0;
    timestep_end  = 1'b1;
    tick();
    timestep_end = 1'b0;
    check("t2_leak_ready", 32'(current_ready), 0);
    check("t2_leak_pv",    32'(potential_valid), 0);
    check("t2_leak_v",     32'(mp), 160);
    tick();
    check("t2_emit_pv", 32'(potential_valid), 1);
    check("t2_emit_v",  32'(mp), 120);
    tick();
    check("t2_after_pv",    32'(potential_valid), 0);
    check("t2_after_v",     32'(mp), 20);
    check("t2_after_ts",    32'(timestep_count), 1);
    check("t2_after_ready", 32'(current_ready), 1);

    // start while busy is ignored.
    do_start();
    check("busy_start_v",     32'(mp), 20);
    check("busy_start_ts",    32'(timestep_count), 1);
    check("busy_start_ready", 32'(current_ready), 1);

    // Reset in the middle of INTEGRATE discards progress.
    p0 = pulses;
    do_reset();
    check("mid_rst_v",     32'(mp), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_ready", 32'(current_ready), 0);
    check("mid_rst_ts",    32'(timestep_count), 0);
    tick(); tick(); tick();
    check("mid_rst_pulses", 32'(pulses - p0), 0);
    check("mid_rst_pv",     32'(potential_valid), 0);

    // Negative potential with leak: -100 - (-25) = -75, below threshold.
    do_start();
    current_valid = 1'b1; current = -16'sd100;
    tick();
    current_valid = 1'b0;
    check("t3_acc", 32'(mp), -100);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    check("t3_emit_pv", 32'(potential_valid), 1);
    check("t3_emit_v",  32'(mp), -75);
    tick();
    check("t3_hold_v", 32'(mp), -75);
    check("t3_ts",     32'(timestep_count), 1);
    // Leak disabled: -75 + 50 = -25 passes through untouched.
    leak_shift    = 4'd0;
    current_valid = 1'b1; current = 16'sd50;
    tick();
    current_valid = 1'b0;
    check("t3_acc2", 32'(mp), -25);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    check("t3_noleak_pv", 32'(potential_valid), 1);
    check("t3_noleak_v",  32'(mp), -25);
    tick();
    check("t3_noleak_hold", 32'(mp), -25);
    check("t3_ts2",         32'(timestep_count), 2);

    // Positive saturation on add, then on threshold subtraction.
    do_reset();
    threshold = -16'sd32768;
    do_start();
    current_valid = 1'b1; current = 16'sd30000;
    tick();
    check("t4_acc1", 32'(mp), 30000);
    tick();
    check("t4_pos_sat", 32'(mp), 32767);
    current_valid = 1'b0;
    timestep_end  = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    check("t4_emit_v", 32'(mp), 32767);
    tick();
    check("t4_sub_sat", 32'(mp), 32767);

    // Negative saturation on add, no wrap and no fire.
    do_reset();
    threshold = 16'sd32767;
    do_start();
    current_valid = 1'b1; current = -16'sd30000;
    tick();
    tick();
    check("t4_neg_sat", 32'(mp), -32768);
    current_valid = 1'b0;
    timestep_end  = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    check("t4_neg_emit_pv", 32'(potential_valid), 1);
    check("t4_neg_emit_v",  32'(mp), -32768);
    tick();
    check("t4_neg_hold", 32'(mp), -32768);

    // Current and timestep_end in the same cycle; held current waits.
    do_reset();
    threshold  = 16'sd100;
    leak_shift = 4'd0;
    do_start();
    current_valid = 1'b1; current = 16'sd3;
    tick();
    check("t5_v3", 32'(mp), 3);
    current = 16'sd7; timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    current      = 16'sd5;
    check("t5_leak_v",     32'(mp), 10);
    check("t5_leak_ready", 32'(current_ready), 0);
    tick();
    check("t5_emit_pv", 32'(potential_valid), 1);
    check("t5_emit_v",  32'(mp), 10);
    tick();
    check("t5_held_not_taken", 32'(mp), 10);
    check("t5_ready",          32'(current_ready), 1);
    check("t5_ts",             32'(timestep_count), 1);
    tick();
    current_valid = 1'b0;
    check("t5_held_taken", 32'(mp), 15);

    // Full four-timestep inference ending in done.
    do_reset();
    threshold  = 16'sd1000;
    leak_shift = 4'd0;
    do_start();
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      current_valid = 1'b1; current = 16'sd10;
      tick();
      current_valid = 1'b0;
      timestep_end  = 1'b1;
      tick();
      timestep_end = 1'b0;
      tick();
      check($sformatf("t6_pv_%0d", k),   32'(potential_valid), 1);
      check($sformatf("t6_v_%0d", k),    32'(mp), 10 * (k + 1));
      check($sformatf("t6_ts_%0d", k),   32'(timestep_count), k);
      check($sformatf("t6_done_%0d", k), 32'(done), 0);
      tick();
      if (k < 3) begin
        check($sformatf("t6_next_ts_%0d", k), 32'(timestep_count), k + 1);
        check($sformatf("t6_busy_%0d", k),    32'(busy), 1);
      end else begin
        check("t6_done_pulse", 32'(done), 1);
        check("t6_idle_busy",  32'(busy), 0);
        check("t6_idle_ts",    32'(timestep_count), 0);
      end
    end
    tick();
    check("t6_done_clear", 32'(done), 0);
    check("t6_pulses",     32'(pulses - p0), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
